// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive FWFT buffer with error and drop statistics
module uart_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 8
) (
    input  logic                       baud,
    input  logic                       reset_n,
    input  logic [DATA_W-1:0]          rx_data,
    input  logic                       rx_done,
    input  logic                       rx_error,
    input  logic                       flush,
    input  logic                       clr_stats,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic [CNT_W-1:0]           err_cnt,
    output logic [CNT_W-1:0]           drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic wr_req, err_evt, pop, wr_en, pop_en, drop;

    // Status flags come from the registered count only, so rd_ready never reaches them.
    always_comb begin
        full     = (count_q == DEPTH_C);
        empty    = (count_q == '0);
        rd_valid = !empty;
        count    = count_q;
        rd_data  = mem[rd_ptr_q];
        overflow = overflow_q;
        err_cnt  = err_cnt_q;
        drop_cnt = drop_cnt_q;
    end

    // Strobe edge detection, write/pop qualification and next-state computation.
    always_comb begin
        done_d  = rx_done;
        err_d   = rx_error;
        wr_req  = rx_done & ~done_q;
        err_evt = rx_error & ~err_q;
        pop     = rd_valid & rd_ready;
        // A pop on a full FIFO frees the slot the incoming byte lands in.
        wr_en   = wr_req & (~full | pop) & ~flush;
        pop_en  = pop & ~flush;
        // A byte swallowed by a flush is discarded on purpose, not dropped.
        drop    = wr_req & full & ~pop & ~flush;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_en) rd_ptr_d = rd_ptr_q + 1'b1;
            if (wr_en && !pop_en) count_d = count_q + 1'b1;
            else if (!wr_en && pop_en) count_d = count_q - 1'b1;
        end

        overflow_d = overflow_q;
        err_cnt_d  = err_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (clr_stats) begin
            overflow_d = 1'b0;
            err_cnt_d  = '0;
            drop_cnt_d = '0;
        end else begin
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != CNT_MAX) drop_cnt_d = drop_cnt_q + 1'b1;
            end
            if (err_evt && err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // Control and statistics registers.
    always_ff @(posedge baud or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            err_cnt_q  <= '0;
            drop_cnt_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            err_cnt_q  <= err_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Byte storage; contents need no reset because count gates visibility.
    always_ff @(posedge baud) begin
        if (wr_en) mem[wr_ptr_q] <= rx_data;
    end
endmodule
